// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
//   Shared definitions for the pushbutton / switch conditioning front end.
//   - deb_state_t : per-channel debounce FSM state encoding (2 bits)
//   - DEBOUNCE_5MS, LONG_1S5, DEF_CNT_W : board defaults at 100 MHz
//   - cnt_fits()  : elaboration helper, true when a counter of the given
//                   width can hold the given value without wrapping
// -----------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } deb_state_t;

    // 5 ms of stable input at 100 MHz
    localparam int unsigned DEBOUNCE_5MS = 32'd500000;
    // 1.5 s of stable press at 100 MHz
    localparam int unsigned LONG_1S5     = 32'd150000000;
    // 2**28 covers both board defaults
    localparam int unsigned DEF_CNT_W    = 32'd28;

    // True when 2**width > value, i.e. the counter can reach value without wrapping.
    function automatic logic cnt_fits(input int unsigned width, input int unsigned value);
        logic [63:0] limit;
        if (width >= 32'd63) begin
            return 1'b1;
        end else begin
            limit = 64'd1 << width;
            return (limit > 64'(value));
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One input channel: 2-flop synchroniser, polarity correction, debounce FSM
//   with a shared check/hold counter, and a sticky long_done bit so that a
//   long press is reported at most once per press.
//
//   Ports
//     clk           in   system clock, rising edge
//     reset         in   synchronous, active-low
//     raw_in        in   asynchronous pin
//     clean_out     out  debounced level, 1 = pressed
//     press_pulse   out  1-cycle strobe on clean_out 0->1
//     release_pulse out  1-cycle strobe on clean_out 1->0
//     long_pulse    out  1-cycle strobe after LONG_DELAY stable pressed cycles
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module debounce_channel
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_DELAY = DEBOUNCE_5MS,
    parameter int unsigned LONG_DELAY     = LONG_1S5,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter logic        ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // Counter compare points, sized to the counter.
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_DELAY);

    logic             sync1_r;
    logic             sync2_r;
    logic             s_in_s;

    deb_state_t       state_r;
    deb_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             clean_r;
    logic             clean_s;
    logic             press_r;
    logic             press_s;
    logic             release_r;
    logic             release_s;
    logic             long_r;
    logic             long_s;
    logic             long_done_r;
    logic             long_done_s;

    // Two-flop synchroniser; reset loads the idle pin level so no phantom edge follows reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= ACTIVE_LOW;
            sync2_r <= ACTIVE_LOW;
        end else begin
            sync1_r <= raw_in;
            sync2_r <= sync1_r;
        end
    end

    // Polarity correction: s_in_s is 1 whenever the button is physically pressed.
    assign s_in_s = sync2_r ^ ACTIVE_LOW;

    // Next-state and next-output logic for the debounce FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        clean_s     = clean_r;
        press_s     = 1'b0;
        release_s   = 1'b0;
        long_s      = 1'b0;
        long_done_s = long_done_r;

        case (state_r)
            IDLE: begin
                clean_s = 1'b0;
                if (s_in_s) begin
                    state_s = CHK_PRESS;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end

            CHK_PRESS: begin
                if (!s_in_s) begin
                    // Any disagreeing sample discards the run.
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = PRESSED;
                    clean_s = 1'b1;
                    press_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!s_in_s) begin
                    state_s = CHK_REL;
                    cnt_s   = CNT_ONE;
                end else begin
                    // Hold counter saturates at LONG_DELAY so it can never wrap back.
                    if (cnt_r != LONG_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if ((cnt_r == LONG_LAST) && !long_done_r) begin
                        long_s      = 1'b1;
                        long_done_s = 1'b1;
                    end else begin
                        long_s      = 1'b0;
                    end
                end
            end

            CHK_REL: begin
                if (s_in_s) begin
                    // Bounce while held: the hold count restarts, long_done stays sticky.
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s     = IDLE;
                    clean_s     = 1'b0;
                    release_s   = 1'b1;
                    long_done_s = 1'b0;
                    cnt_s       = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s     = IDLE;
                cnt_s       = CNT_ZERO;
                clean_s     = 1'b0;
                long_done_s = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            clean_r     <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            long_r      <= 1'b0;
            long_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            clean_r     <= clean_s;
            press_r     <= press_s;
            release_r   <= release_s;
            long_r      <= long_s;
            long_done_r <= long_done_s;
        end
    end

    assign clean_out     = clean_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Conditioning stage for board pushbuttons / slide switches. Each of the
//   N_INPUTS channels is synchronised, debounced and turned into a clean level
//   plus press, release and long-press strobes. Channels are independent.
//
//   Ports
//     clk            in   1         system clock, rising edge
//     reset          in   1         synchronous, active-low
//     raw_in         in   N_INPUTS  asynchronous pins
//     clean_out      out  N_INPUTS  debounced level, 1 = pressed
//     press_pulse    out  N_INPUTS  1-cycle strobe on clean_out 0->1
//     release_pulse  out  N_INPUTS  1-cycle strobe on clean_out 1->0
//     long_pulse     out  N_INPUTS  1-cycle strobe after LONG_DELAY held cycles
//
//   ACTIVE_LOW bit i = 1 means pin i reads 0 when pressed.
//   Raw edge to clean_out / strobe latency is 2 + DEBOUNCE_DELAY cycles.
// -----------------------------------------------------------------------------
module input_debouncer
    import input_pkg::*;
#(
    parameter int unsigned          N_INPUTS       = 32'd3,
    parameter int unsigned          DEBOUNCE_DELAY = DEBOUNCE_5MS,
    parameter int unsigned          LONG_DELAY     = LONG_1S5,
    parameter int unsigned          CNT_W          = DEF_CNT_W,
    parameter logic [N_INPUTS-1:0]  ACTIVE_LOW     = {N_INPUTS{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] raw_in,
    output logic [N_INPUTS-1:0] clean_out,
    output logic [N_INPUTS-1:0] press_pulse,
    output logic [N_INPUTS-1:0] release_pulse,
    output logic [N_INPUTS-1:0] long_pulse
);

    localparam int unsigned MAX_DELAY =
        (DEBOUNCE_DELAY > LONG_DELAY) ? DEBOUNCE_DELAY : LONG_DELAY;

    // Refuse to build a counter that could wrap before reaching either delay.
    if (!cnt_fits(CNT_W, MAX_DELAY)) begin : g_cnt_w_too_small
        $error("input_debouncer: CNT_W=%0d cannot hold delay %0d", CNT_W, MAX_DELAY);
    end

    // The check counter starts at 1 on the first agreeing sample, so a delay of 1 cannot be expressed.
    if ((DEBOUNCE_DELAY < 32'd2) || (LONG_DELAY < 32'd1)) begin : g_delay_too_small
        $error("input_debouncer: DEBOUNCE_DELAY must be >= 2 and LONG_DELAY >= 1");
    end

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_DELAY (DEBOUNCE_DELAY),
            .LONG_DELAY     (LONG_DELAY),
            .CNT_W          (CNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW[i])
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .raw_in        (raw_in[i]),
            .clean_out     (clean_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int         D    = 8;
    localparam int         L    = 20;
    localparam logic [2:0] MASK = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] raw_in;
    logic [2:0] clean_out;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;
    logic [2:0] long_pulse;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .N_INPUTS       (3),
        .DEBOUNCE_DELAY (D),
        .LONG_DELAY     (L),
        .CNT_W          (6),
        .ACTIVE_LOW     (MASK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .clean_out     (clean_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    // Reference model: pins reach the decision logic two samples late; a level
    // is accepted after D consecutive disagreeing samples; a long press is L
    // consecutive held samples counted after the press (or after a bounce ends).
    logic [2:0] m_p1, m_p2;
    logic [2:0] m_clean, m_press, m_rel, m_long, m_prev, m_ldone;
    int         m_run [3];
    int         m_hold[3];

    int seg_press[3];
    int seg_rel  [3];
    int seg_long [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic [2:0] raw_v);
        logic [2:0] samp;
        m_press = 3'b000;
        m_rel   = 3'b000;
        m_long  = 3'b000;
        if (!rst_v) begin
            m_p1    = MASK;
            m_p2    = MASK;
            m_clean = 3'b000;
            m_prev  = 3'b000;
            m_ldone = 3'b000;
            for (int c = 0; c < 3; c++) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end
        end else begin
            samp = m_p2 ^ MASK;
            m_p2 = m_p1;
            m_p1 = raw_v;
            for (int c = 0; c < 3; c++) begin
                if (samp[c] != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_clean[c] = samp[c];
                        m_run[c]   = 0;
                        if (samp[c]) begin
                            m_press[c] = 1'b1;
                            m_hold[c]  = 0;
                        end else begin
                            m_rel[c]   = 1'b1;
                            m_ldone[c] = 1'b0;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_clean[c] && samp[c] && !m_press[c]) begin
                    m_hold[c] = m_prev[c] ? m_hold[c] + 1 : 0;
                    if ((m_hold[c] == L) && !m_ldone[c]) begin
                        m_long[c]  = 1'b1;
                        m_ldone[c] = 1'b1;
                    end
                end
                m_prev[c] = samp[c];
            end
        end
    endtask

    // One clock: capture inputs, advance model at the edge, compare on the falling edge.
    task automatic step();
        logic       r;
        logic [2:0] rv;
        r  = reset;
        rv = raw_in;
        @(posedge clk);
        model_edge(r, rv);
        @(negedge clk);
        check("cycle {clean,press,release,long}",
              {20'd0, clean_out, press_pulse, release_pulse, long_pulse},
              {20'd0, m_clean, m_press, m_rel, m_long});
        for (int c = 0; c < 3; c++) begin
            seg_press[c] += int'(press_pulse[c]);
            seg_rel[c]   += int'(release_pulse[c]);
            seg_long[c]  += int'(long_pulse[c]);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [2:0] raw;
        int         cycles;
        logic [2:0] clean;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lng;
    } seg_t;

    seg_t tbl[$];

    initial begin
        logic [2:0] flip;
        int         hold;

        reset  = 1'b0;
        raw_in = 3'b110;

        // rst_n, raw, cycles, clean@end, press/release/long channels pulsing once in segment
        tbl.push_back('{1'b0, 3'b110,  3, 3'b000, 3'b000, 3'b000, 3'b000}); // reset, pins ignored
        tbl.push_back('{1'b1, 3'b001, 12, 3'b000, 3'b000, 3'b000, 3'b000}); // idle after release
        tbl.push_back('{1'b1, 3'b000,  9, 3'b000, 3'b000, 3'b000, 3'b000}); // ch0 pressed, not yet
        tbl.push_back('{1'b1, 3'b000,  1, 3'b001, 3'b001, 3'b000, 3'b000}); // ch0 accepted at 10
        tbl.push_back('{1'b1, 3'b000,  5, 3'b001, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b010,  5, 3'b001, 3'b000, 3'b000, 3'b000}); // ch1 bounce high 5
        tbl.push_back('{1'b1, 3'b000,  1, 3'b001, 3'b000, 3'b000, 3'b000}); // low 1
        tbl.push_back('{1'b1, 3'b010,  8, 3'b001, 3'b000, 3'b000, 3'b000}); // final high run
        tbl.push_back('{1'b1, 3'b010,  1, 3'b001, 3'b000, 3'b000, 3'b001}); // ch0 long, 20 after press
        tbl.push_back('{1'b1, 3'b010,  1, 3'b011, 3'b010, 3'b000, 3'b000}); // ch1 press, 10 after rise
        tbl.push_back('{1'b1, 3'b010,  2, 3'b011, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b110,  9, 3'b011, 3'b000, 3'b000, 3'b000}); // ch2 pressed
        tbl.push_back('{1'b1, 3'b110,  1, 3'b111, 3'b100, 3'b000, 3'b000}); // ch2 accepted
        tbl.push_back('{1'b1, 3'b110,  7, 3'b111, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b110,  1, 3'b111, 3'b000, 3'b000, 3'b010}); // ch1 long
        tbl.push_back('{1'b1, 3'b110, 11, 3'b111, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b110,  1, 3'b111, 3'b000, 3'b000, 3'b100}); // ch2 long, 20 after press
        tbl.push_back('{1'b1, 3'b110,  5, 3'b111, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b010,  3, 3'b111, 3'b000, 3'b000, 3'b000}); // ch2 3-cycle glitch
        tbl.push_back('{1'b1, 3'b110, 30, 3'b111, 3'b000, 3'b000, 3'b000}); // no second long, no release
        tbl.push_back('{1'b1, 3'b101,  9, 3'b111, 3'b000, 3'b000, 3'b000}); // release ch0+ch1 together
        tbl.push_back('{1'b1, 3'b101,  1, 3'b100, 3'b000, 3'b011, 3'b000});
        tbl.push_back('{1'b1, 3'b101,  3, 3'b100, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b0, 3'b101,  1, 3'b000, 3'b000, 3'b000, 3'b000}); // reset while ch2 held
        tbl.push_back('{1'b1, 3'b101,  9, 3'b000, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b101,  1, 3'b100, 3'b100, 3'b000, 3'b000}); // ch2 re-press at 10
        tbl.push_back('{1'b1, 3'b101,  4, 3'b100, 3'b000, 3'b000, 3'b000});

        foreach (tbl[i]) begin
            reset  = tbl[i].rst_n;
            raw_in = tbl[i].raw;
            for (int c = 0; c < 3; c++) begin
                seg_press[c] = 0;
                seg_rel[c]   = 0;
                seg_long[c]  = 0;
            end
            repeat (tbl[i].cycles) step();
            check($sformatf("seg%0d clean_out", i), {29'd0, clean_out}, {29'd0, tbl[i].clean});
            for (int c = 0; c < 3; c++) begin
                check($sformatf("seg%0d press count ch%0d", i, c), seg_press[c], {31'd0, tbl[i].press[c]});
                check($sformatf("seg%0d release count ch%0d", i, c), seg_rel[c], {31'd0, tbl[i].rel[c]});
                check($sformatf("seg%0d long count ch%0d", i, c), seg_long[c], {31'd0, tbl[i].lng[c]});
            end
        end

        // Random phase: per-channel flips with mixed hold lengths, occasional reset.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0;
            flip  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            raw_in = raw_in ^ flip;
            if (!reset) begin
                hold = $urandom_range(1, 3);
            end else if ($urandom_range(0, 3) == 0) begin
                hold = $urandom_range(20, 45);
            end else begin
                hold = $urandom_range(1, 12);
            end
            repeat (hold) step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
